// File: rtl/seg_scan_ctrl_if.sv
// Write/scan bus of the multiplexed 7-segment scan controller.
interface seg_scan_ctrl_if #(parameter int DIGITS = 4);
  localparam int AW = $clog2(DIGITS);

  logic              en;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [3:0]        wr_data;
  logic              swap;
  logic              swap_pending;
  logic [3:0]        nib;
  logic [DIGITS-1:0] an;
  logic              frame_done;

  modport master (output en, wr_en, wr_addr, wr_data, swap,
                  input  swap_pending, nib, an, frame_done);
  modport slave  (input  en, wr_en, wr_addr, wr_data, swap,
                  output swap_pending, nib, an, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding one shared hex-to-7-segment decoder,
// with a double-buffered nibble per digit and blanking between digits.
module seg_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       copy,
  input  logic [3:0] data,
  output logic [3:0] act,
  output logic [3:0] act_nxt
);
  logic [3:0] shadow, shadow_nxt;

  // A copy sees a same-cycle write (write-through into the active buffer).
  always_comb begin
    shadow_nxt = wr ? data : shadow;
    act_nxt    = copy ? shadow_nxt : act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      act    <= '0;
    end else begin
      shadow <= shadow_nxt;
      act    <= act_nxt;
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 2
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int AW = $clog2(DIGITS);
  localparam int CW = $clog2(((DWELL > BLANK) ? DWELL : BLANK) + 1);
  localparam logic [CW-1:0] DW_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [AW-1:0] LAST  = AW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLNK, SHOW} state_t;

  state_t            state, state_n;
  logic [AW-1:0]     d, d_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              boundary, copy;
  logic              pend;
  logic [3:0]        nib_r;
  logic [DIGITS-1:0] an_r;
  logic              fd_r;
  logic [DIGITS-1:0][3:0] act, act_nxt;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg_digit u_dig (
      .clk     (clk),
      .rst     (rst),
      .wr      (bus.wr_en && (bus.wr_addr == AW'(i))),
      .copy    (copy),
      .data    (bus.wr_data),
      .act     (act[i]),
      .act_nxt (act_nxt[i])
    );
  end

  always_comb begin
    state_n  = state;
    d_n      = d;
    cnt_n    = cnt;
    boundary = 1'b0;
    case (state)
      IDLE: begin
        d_n   = '0;
        cnt_n = '0;
        if (bus.en) begin
          if (BLANK == 0) begin
            state_n = SHOW;
            cnt_n   = DW_LD;
          end else begin
            state_n = BLNK;
            cnt_n   = BL_LD;
          end
        end
      end
      BLNK: begin
        if (!bus.en) begin
          state_n = IDLE;
          d_n     = '0;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n = SHOW;
          cnt_n   = DW_LD;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_n = IDLE;
          d_n     = '0;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          boundary = (d == LAST);
          d_n      = boundary ? '0 : d + AW'(1);
          if (BLANK == 0) begin
            state_n = SHOW;
            cnt_n   = DW_LD;
          end else begin
            state_n = BLNK;
            cnt_n   = BL_LD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // IDLE behaves as a permanent frame boundary for swap purposes.
  assign copy = (boundary || (state == IDLE)) && (pend || bus.swap);

  // an/nib are registered from the next state so they line up with it;
  // nib uses post-copy data so a swapped digit never flashes old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      d     <= '0;
      cnt   <= '0;
      an_r  <= '0;
      nib_r <= '0;
      fd_r  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      d     <= d_n;
      cnt   <= cnt_n;
      an_r  <= (state_n == SHOW) ? (DIGITS'(1) << d_n) : '0;
      nib_r <= (state_n == IDLE) ? 4'h0 : act_nxt[d_n];
      fd_r  <= boundary;
      pend  <= copy ? 1'b0 : (pend | bus.swap);
    end
  end

  assign bus.an           = an_r;
  assign bus.nib          = nib_r;
  assign bus.frame_done   = fd_r;
  assign bus.swap_pending = pend;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors plus scripted scan sequences,
// expectations queued at drive time and compared after each edge.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(4)) ifa ();
  seg_scan_ctrl_if #(.DIGITS(4)) ifb ();

  seg_scan_ctrl #(.DIGITS(4), .DWELL(3), .BLANK(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  seg_scan_ctrl #(.DIGITS(4), .DWELL(3), .BLANK(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       fd;
    logic       sp;
  } obs_t;

  typedef struct {
    bit         rst;
    bit         en;
    bit         wr;
    logic [1:0] a;
    logic [3:0] dt;
    bit         sw;
    obs_t       exp;
  } vec_t;

  obs_t q[$];
  int   vecs = 0;
  int   errs = 0;

  // bench-side view of the buffers for DUT A
  logic [3:0] sh[4];
  logic [3:0] disp[4];
  bit         pend;
  bit         a_idle;
  int         c;

  int an_tab[16]  = '{0,1,1,1, 0,2,2,2, 0,4,4,4, 0,8,8,8};
  int anb_tab[12] = '{1,1,1, 2,2,2, 4,4,4, 8,8,8};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input bit sel_b, input string name);
    obs_t e, g;
    e = q.pop_front();
    if (sel_b) g = {ifb.an, ifb.nib, ifb.frame_done, ifb.swap_pending};
    else       g = {ifa.an, ifa.nib, ifa.frame_done, ifa.swap_pending};
    vecs++;
    if (g !== e) begin
      errs++;
      $display("FAIL %s: got an=%h nib=%h fd=%b sp=%b, want an=%h nib=%h fd=%b sp=%b",
               name, g.an, g.nib, g.fd, g.sp, e.an, e.nib, e.fd, e.sp);
    end
  endtask

  task automatic drive_a(input bit en, input bit wr, input logic [1:0] a,
                         input logic [3:0] dt, input bit sw);
    ifa.en = en; ifa.wr_en = wr; ifa.wr_addr = a; ifa.wr_data = dt; ifa.swap = sw;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin sh[i] = 4'h0; disp[i] = 4'h0; end
    pend = 0; a_idle = 1; c = 0;
  endtask

  task automatic scan_a(input bit wr, input logic [1:0] a, input logic [3:0] dt,
                        input bit sw, input string name);
    int   s;
    bit   bnd;
    obs_t e;
    s   = c % 16;
    bnd = (s == 0) && (c >= 16);
    drive_a(1, wr, a, dt, sw);
    if (wr) sh[a] = dt;
    if (bnd && (pend || sw)) begin disp = sh; pend = 0; end
    else if (sw) pend = 1;
    e.an = 4'(an_tab[s]); e.nib = disp[s/4]; e.fd = bnd; e.sp = pend;
    q.push_back(e);
    a_idle = 0;
    tick();
    check(0, name);
    c++;
  endtask

  task automatic idle_a(input bit wr, input logic [1:0] a, input logic [3:0] dt,
                        input bit sw, input string name);
    obs_t e;
    drive_a(0, wr, a, dt, sw);
    if (wr) sh[a] = dt;
    if (a_idle && (pend || sw)) begin disp = sh; pend = 0; end
    else if (sw) pend = 1;
    e = '{an: 4'h0, nib: 4'h0, fd: 1'b0, sp: pend};
    q.push_back(e);
    a_idle = 1; c = 0;
    tick();
    check(0, name);
  endtask

  initial begin
    vec_t tab[8];
    obs_t z;
    z = '0;
    tab[0] = '{rst:1, en:1, wr:1, a:2'd0, dt:4'h5, sw:1, exp:z};
    tab[1] = '{rst:1, en:0, wr:0, a:2'd0, dt:4'h0, sw:0, exp:z};
    tab[2] = '{rst:0, en:0, wr:1, a:2'd0, dt:4'h1, sw:0, exp:z};
    tab[3] = '{rst:0, en:0, wr:1, a:2'd1, dt:4'h2, sw:0, exp:z};
    tab[4] = '{rst:0, en:0, wr:1, a:2'd2, dt:4'h3, sw:0, exp:z};
    tab[5] = '{rst:0, en:0, wr:1, a:2'd3, dt:4'h4, sw:0, exp:z};
    tab[6] = '{rst:0, en:0, wr:0, a:2'd0, dt:4'h0, sw:1, exp:z};
    tab[7] = '{rst:0, en:0, wr:0, a:2'd0, dt:4'h0, sw:0, exp:z};

    rst = 1'b1;
    drive_a(0, 0, 2'd0, 4'h0, 0);
    ifb.en = 0; ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.swap = 0;

    // reset, idle writes and an idle swap
    for (int i = 0; i < 8; i++) begin
      rst = tab[i].rst;
      drive_a(tab[i].en, tab[i].wr, tab[i].a, tab[i].dt, tab[i].sw);
      q.push_back(tab[i].exp);
      tick();
      check(0, $sformatf("vec%0d", i));
    end
    model_clear();
    sh   = '{4'h1, 4'h2, 4'h3, 4'h4};
    disp = '{4'h1, 4'h2, 4'h3, 4'h4};

    for (int i = 0; i < 20; i++) idle_a(0, 2'd0, 4'h0, 0, "idle");

    // frames 0..5: hidden write, deferred swap, boundary-coincident swap
    for (int k = 0; k < 96; k++) begin
      if (k == 20)      scan_a(1, 2'd1, 4'h9, 0, "hidden_wr");
      else if (k == 38) scan_a(1, 2'd0, 4'hF, 1, "defer_swap");
      else if (k == 80) scan_a(1, 2'd3, 4'hA, 1, "bnd_swap");
      else              scan_a(0, 2'd0, 4'h0, 0, $sformatf("scan%0d", k));
    end

    // into SHOW of digit 2, then disable
    for (int k = 0; k < 10; k++) scan_a(0, 2'd0, 4'h0, 0, "pre_dis");
    for (int k = 0; k < 3; k++)  idle_a(0, 2'd0, 4'h0, 0, "disabled");
    for (int k = 0; k < 20; k++) scan_a(0, 2'd0, 4'h0, 0, "restart");

    // pending swap discarded by reset mid-SHOW
    scan_a(0, 2'd0, 4'h0, 1, "swap_pend");
    scan_a(0, 2'd0, 4'h0, 0, "pend_hold");
    rst = 1'b1;
    drive_a(1, 0, 2'd0, 4'h0, 0);
    q.push_back(z);
    tick();
    check(0, "rst_mid_show");
    rst = 1'b0;
    model_clear();
    idle_a(0, 2'd0, 4'h0, 0, "post_rst");

    // BLANK=0 variant on DUT B
    for (int i = 0; i < 5; i++) begin
      ifb.wr_en = (i < 4); ifb.wr_addr = 2'(i); ifb.wr_data = 4'(i + 5); ifb.swap = (i == 4);
      q.push_back(z);
      tick();
      check(1, "b_load");
    end
    ifb.wr_en = 0; ifb.swap = 0; ifb.en = 1;
    for (int k = 0; k < 30; k++) begin
      obs_t e;
      int   s;
      s = k % 12;
      e.an = 4'(anb_tab[s]); e.nib = 4'(s / 3 + 5); e.fd = (s == 0) && (k >= 12); e.sp = 1'b0;
      q.push_back(e);
      tick();
      check(1, $sformatf("b_scan%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares one combinational hex-to-7-segment decoder among several display digits. It holds a double-buffered nibble per digit and sequences the digits in turn: it drives the selected nibble to the shared decoder and asserts one-hot digit enables, with a blanking gap between digits to suppress ghosting. It sits between the register/write interface and the decoder: `nib` feeds the decoder's 4-bit input, and `an` gates the common digit drivers.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, range 2..8.
- `DWELL`, default 1000: cycles each digit is lit, ≥1.
- `BLANK`, default 2: all-off cycles before each digit, ≥0.
- `clk  in  1`: the single clock; all state changes on its rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `en  in  1`: scan enable.
- `wr_en  in  1`: write strobe into the shadow buffer.
- `wr_addr  in  clog2(DIGITS)`: shadow digit index. Writes with out-of-range indices are ignored.
- `wr_data  in  4`: nibble to write.
- `swap  in  1`: request to copy shadow into active at the next frame boundary.
- `swap_pending  out  1`: high while a swap request is waiting.
- `nib  out  4`: nibble to the shared decoder (registered).
- `an  out  DIGITS`: one-hot active-high digit enable (registered).
- `frame_done  out  1`: one-cycle pulse per completed frame.

## Operation
- Storage:
  - `shadow[DIGITS]` is written when `wr_en` is high; writes are always accepted, with no backpressure.
  - `active[DIGITS]` is the buffer that is displayed.
- State machine: IDLE, BLNK, SHOW.
  - **IDLE:** `an`=0, `nib`=0, digit index `d`=0, counter=0. When `en`=1, go to BLNK with `d`=0. If `BLANK`=0, go directly to SHOW.
  - **BLNK:** lasts `BLANK` cycles. `an`=0, `nib`=`active[d]`, so the decoder output settles before the digit is lit. Then go to SHOW.
  - **SHOW:** lasts `DWELL` cycles. `an`=1<<`d`, `nib`=`active[d]`. Then:
    - increment `d`, wrapping `DIGITS`-1 → 0;
    - go to BLNK, or to SHOW when `BLANK`=0.
- Frame boundary: the edge that ends SHOW of digit `DIGITS`-1.
  - At that edge `frame_done` is registered high for one cycle.
  - A pending swap is applied at the same edge.
- Swap:
  - `swap`=1 sets `swap_pending`, unless a boundary edge occurs in the same cycle. In that case the copy happens at that edge and `swap_pending` stays 0.
  - `swap` while already pending has no further effect.
  - The copy includes a `wr_en` write in the same cycle, i.e. write-through to `active`.
  - While scanning is disabled (IDLE), a pending swap is applied on the first edge in IDLE.
- `en` deassertion from BLNK or SHOW: the next edge goes to IDLE. `an` is 0 from that edge, `d` and the counter are cleared, and `frame_done` is not pulsed.
- The counter is sized clog2(max(`DWELL`,`BLANK`)+1) bits and counts down to 0. No other arithmetic.
- Frame period is `DIGITS`×(`BLANK`+`DWELL`) cycles.

## Timing
- Reset values (edge with `rst`=1, overriding all other inputs):
  - `an`=0, `nib`=0, `frame_done`=0, `swap_pending`=0;
  - state IDLE, `d`=0, counter=0;
  - all `shadow` and `active` entries = 0.
- Latency:
  - `en` rise at edge k: BLNK from edge k+1, and the first `an` bit high at edge k+1+`BLANK`.
  - `en` fall at edge k: `an`=0 after edge k.
- A write becomes visible on `nib` only after a swap, never directly.
- At most one `an` bit is high in any cycle. `an` never switches directly between two non-zero values when `BLANK`≥1.
- Reset mid-SHOW: `an`=0 the cycle after the reset edge. A pending swap is discarded.

## Test plan
Parameters for all cases: `DIGITS`=4, `DWELL`=3, `BLANK`=1.
- **Reset/idle:** hold `rst` 2 cycles, `en`=0 → `an`=0, `nib`=0, `frame_done`=0, `swap_pending`=0 for 20 cycles.
- **Basic scan:** write 1,2,3,4 to addresses 0..3, pulse `swap`, set `en`=1 →
  - `an` sequence per 16-cycle frame: 0,1,1,1,0,2,2,2,0,4,4,4,0,8,8,8;
  - `nib` = 1,2,3,4 during the matching slots;
  - `frame_done` pulses every 16 cycles.
- **Deferred swap:** during digit 1 of a frame, write 0xF to address 0 and pulse `swap` →
  - `swap_pending`=1 until the frame boundary;
  - digit 0 shows 1 for the rest of this frame and 0xF in the next frame.
- **Boundary coincidence:** `swap` with `wr_en` (addr 3, data 0xA) on the boundary cycle →
  - `swap_pending` stays 0;
  - digit 3 shows 0xA in the next frame.
- **Disable mid-SHOW:** drop `en` during SHOW of digit 2 → `an`=0 next cycle. Re-enable → the scan restarts at digit 0 after 1 blank cycle.
- **`BLANK`=0 variant:** `an` goes 1,1,1,2,2,2,4,... with no zero cycles; `frame_done` period is 12.
